neuron_layer: RTL

NEURON_LAYER -- requirements
Module: neuron_layer

---
 rtl/nn_layer_pkg.sv | 30 +++
 rtl/neuron_mac.sv | 79 +++++++
 rtl/neuron_layer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/nn_layer_pkg.sv
// Shared state encoding and width helpers for the neuron_layer datapath.
package nn_layer_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int prod_width(input int in_w, input int w_w);
    return in_w + w_w + 1;
  endfunction

  // One extra bit per doubling of the term count keeps the sum from overflowing.
  function automatic int acc_width(input int in_w, input int w_w, input int n);
    return prod_width(in_w, w_w) + clog2(n);
  endfunction

  function automatic int shift_width(input int in_frac, input int w_frac, input int out_frac);
    return in_frac + w_frac - out_frac;
  endfunction

  function automatic int count_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// One neuron: signed multiply-accumulate, floor rescale and output reduction.
// NEURON_LAYER_SAT_EN selects saturation instead of wrap-around on the result.
module neuron_mac
  import nn_layer_pkg::*;
#(
  parameter int NUM_NEURON      = 6,
  parameter int INPUT_SIZE      = 9,
  parameter int WEIGHT_SIZE     = 17,
  parameter int INPUT_FRACTION  = 8,
  parameter int WEIGHT_FRACTION = 8,
  parameter int FRACTION_BITS   = 7,
  parameter int ADDR_SIZE       = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   acc_en,
  input  logic                   last,
  input  logic                   keep,
  input  logic                   term_en,
  input  logic [INPUT_SIZE-1:0]  x,
  input  logic [WEIGHT_SIZE-1:0] weight,
  output logic [ADDR_SIZE-1:0]   result
);

  localparam int PW = prod_width(INPUT_SIZE, WEIGHT_SIZE);
  localparam int AW = acc_width(INPUT_SIZE, WEIGHT_SIZE, NUM_NEURON);
  localparam int SH = shift_width(INPUT_FRACTION, WEIGHT_FRACTION, FRACTION_BITS);

  logic signed [PW-1:0]  x_ext;
  logic signed [PW-1:0]  w_ext;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  acc_next;
  logic signed [AW-1:0]  shifted;
  logic [ADDR_SIZE-1:0]  reduced;

`ifdef NEURON_LAYER_SAT_EN
  localparam logic signed [AW-1:0] MAX_V = AW'((64'sd1 <<< (ADDR_SIZE - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] MIN_V = ~MAX_V;
`endif

  always_comb begin
    x_ext    = PW'(x);
    w_ext    = PW'($signed(weight));
    prod     = x_ext * w_ext;
    acc_next = acc + (term_en ? AW'(prod) : '0);
    shifted  = acc_next >>> SH;
`ifdef NEURON_LAYER_SAT_EN
    if (shifted > MAX_V) begin
      reduced = {1'b0, {(ADDR_SIZE-1){1'b1}}};
    end else if (shifted < MIN_V) begin
      reduced = {1'b1, {(ADDR_SIZE-1){1'b0}}};
    end else begin
      reduced = ADDR_SIZE'(shifted);
    end
`else
    reduced = ADDR_SIZE'(shifted);
`endif
  end

  // The result register captures the final sum on the same edge as the last add.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (clear) begin
        acc <= '0;
      end else if (acc_en) begin
        acc <= acc_next;
      end
      if (last) begin
        result <= keep ? reduced : '0;
      end
    end
  end

endmodule

// File: rtl/neuron_layer.sv
// Fully connected layer: FSM plus shared input counter feeding NUM_NEURON neuron_mac units.
// Define NEURON_LAYER_SAT_EN to saturate outputs instead of wrapping them.
module neuron_layer
  import nn_layer_pkg::*;
#(
  parameter int NUM_NEURON      = 6,
  parameter int INPUT_SIZE      = 9,
  parameter int WEIGHT_SIZE     = 17,
  parameter int INPUT_FRACTION  = 8,
  parameter int WEIGHT_FRACTION = 8,
  parameter int FRACTION_BITS   = 7,
  parameter int ADDR_SIZE       = 10
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      layer_start,
  input  logic [NUM_NEURON-1:0]                     active,
  input  logic [NUM_NEURON*INPUT_SIZE-1:0]          layer_input,
  input  logic [NUM_NEURON*NUM_NEURON*WEIGHT_SIZE-1:0] layer_weights,
  output logic [NUM_NEURON*ADDR_SIZE-1:0]           layer_output,
  output logic [NUM_NEURON-1:0]                     layer_output_valid,
  output logic                                      busy
);

  localparam int CW = count_width(NUM_NEURON);
  localparam logic [CW-1:0] LAST = CW'(NUM_NEURON - 1);

  state_t                                      state;
  state_t                                      state_next;
  logic [CW-1:0]                               cnt;
  logic [NUM_NEURON-1:0]                       act_r;
  logic [NUM_NEURON*INPUT_SIZE-1:0]            in_r;
  logic [NUM_NEURON*NUM_NEURON*WEIGHT_SIZE-1:0] w_r;
  logic                                        load;
  logic                                        mac_en;
  logic                                        mac_last;
  logic [INPUT_SIZE-1:0]                       x_k;
  logic                                        term_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      act_r <= '0;
      in_r  <= '0;
      w_r   <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        cnt   <= '0;
        act_r <= active;
        in_r  <= layer_input;
        w_r   <= layer_weights;
      end else if (mac_en) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_next         = state;
    load               = 1'b0;
    mac_en             = 1'b0;
    mac_last           = 1'b0;
    busy               = 1'b1;
    layer_output_valid = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (layer_start) begin
          load       = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (cnt == LAST) begin
          mac_last   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        layer_output_valid = act_r;
        state_next         = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Input k is broadcast to every neuron; inactive inputs contribute a zero term.
  assign x_k     = in_r[int'(cnt)*INPUT_SIZE +: INPUT_SIZE];
  assign term_en = act_r[cnt];

  for (genvar j = 0; j < NUM_NEURON; j++) begin : g_neuron
    logic [WEIGHT_SIZE-1:0] w_jk;
    assign w_jk = w_r[(j*NUM_NEURON + int'(cnt))*WEIGHT_SIZE +: WEIGHT_SIZE];

    neuron_mac #(
      .NUM_NEURON      (NUM_NEURON),
      .INPUT_SIZE      (INPUT_SIZE),
      .WEIGHT_SIZE     (WEIGHT_SIZE),
      .INPUT_FRACTION  (INPUT_FRACTION),
      .WEIGHT_FRACTION (WEIGHT_FRACTION),
      .FRACTION_BITS   (FRACTION_BITS),
      .ADDR_SIZE       (ADDR_SIZE)
    ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .clear   (load),
      .acc_en  (mac_en),
      .last    (mac_last),
      .keep    (act_r[j]),
      .term_en (term_en),
      .x       (x_k),
      .weight  (w_jk),
      .result  (layer_output[j*ADDR_SIZE +: ADDR_SIZE])
    );
  end

endmodule
